// File: rtl/rec_pkg.sv
// Shared definitions for the sample reconstruction path: scan-area codes,
// FSM state type and width helpers also used by cal_d_delta.
package rec_pkg;

  localparam logic [4:0] AREA_INI = 5'b00001;
  localparam logic [4:0] AREA_A1  = 5'b00010;
  localparam logic [4:0] AREA_A2  = 5'b00100;
  localparam logic [4:0] AREA_A3  = 5'b01000;
  localparam logic [4:0] AREA_A4  = 5'b10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rec_state_e;

  // Counter width able to hold the value max_nx itself.
  function automatic int nx_width(input int max_nx);
    return $clog2(max_nx + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rec_line_buf.sv
// One row of reconstructed samples: two combinational read ports, one
// registered write port. Contents are deliberately left unreset.
module rec_line_buf
  import rec_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 64,
  parameter int AW         = 7
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr0_i,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  input  logic [AW-1:0]         raddr1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o
);

  localparam int IW = idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < AW'(DEPTH))) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

  // The north-east port may point one past the row end; return zero there.
  assign rdata0_o = (raddr0_i < AW'(DEPTH)) ? mem_q[raddr0_i[IW-1:0]] : '0;
  assign rdata1_o = (raddr1_i < AW'(DEPTH)) ? mem_q[raddr1_i[IW-1:0]] : '0;

endmodule

// File: rtl/rec_s_delta.sv
// Reconstructs samples S from local differences d = 4*S - delta, where delta
// is predicted from already reconstructed neighbours; one result per sample.
module rec_s_delta
  import rec_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int D_WIDTH    = DATA_WIDTH + 3,
  parameter int MAX_NX     = 64,
  localparam int NX_W      = nx_width(MAX_NX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [NX_W-1:0]       nx_i,
  input  logic [15:0]           ny_i,
  input  logic                  en_i,
  input  logic [D_WIDTH-1:0]    d_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] s_o,
  output logic                  last_o,
  output logic                  err_o,
  output logic                  busy_o
);

  // D_WIDTH must be at least DATA_WIDTH+3 for the sum slicing below.
  localparam int SUM_W = D_WIDTH + 1;
  localparam int DLT_W = DATA_WIDTH + 2;

  rec_state_e            state_q;
  logic [NX_W-1:0]       x_q, nx_q, x_ne;
  logic [15:0]           y_q, ny_q;
  logic [DATA_WIDTH-1:0] snw_q, s_q, sn, sne, s_clamp;
  logic                  en_q, last_q, err_q;
  logic                  cfg_ok, start_ok, accept, drop, x_end, y_end;
  logic                  neg, over, inexact, err_d;
  logic [4:0]            area;
  logic [DLT_W-1:0]      delta;
  logic signed [SUM_W-1:0] sum;

  assign x_ne = x_q + NX_W'(1);

  rec_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_NX),
    .AW         (NX_W)
  ) u_line_buf (
    .clk      (clk),
    .we_i     (accept),
    .waddr_i  (x_q),
    .wdata_i  (s_clamp),
    .raddr0_i (x_q),
    .rdata0_o (sn),
    .raddr1_i (x_ne),
    .rdata1_o (sne)
  );

  always_comb begin
    cfg_ok   = (nx_i >= NX_W'(2)) && (nx_i <= NX_W'(MAX_NX)) && (ny_i != 16'd0);
    start_ok = start_i && cfg_ok;
    accept   = en_i && (state_q == ST_RUN) && !start_ok;
    drop     = en_i && !accept;
    x_end    = (x_q == nx_q - NX_W'(1));
    y_end    = (y_q == ny_q - 16'd1);

    if (x_q == '0 && y_q == '0)  area = AREA_INI;
    else if (y_q == '0)          area = AREA_A2;
    else if (x_q == '0)          area = AREA_A3;
    else if (x_end)              area = AREA_A4;
    else                         area = AREA_A1;

    // West neighbour comes straight from the output register.
    case (area)
      AREA_A1: delta = DLT_W'(snw_q) + {1'b0, sn, 1'b0} + DLT_W'(sne);
      AREA_A2: delta = {s_q, 2'b00};
      AREA_A3: delta = {1'b0, sn, 1'b0} + {1'b0, sne, 1'b0};
      AREA_A4: delta = {1'b0, snw_q, 1'b0} + {1'b0, sn, 1'b0};
      default: delta = '0;
    endcase

    sum     = $signed({{(SUM_W-DLT_W){1'b0}}, delta}) + $signed({d_i[D_WIDTH-1], d_i});
    neg     = sum[SUM_W-1];
    over    = !neg && (|sum[SUM_W-2:DATA_WIDTH+2]);
    inexact = |sum[1:0];
    s_clamp = neg ? '0 : (over ? '1 : sum[DATA_WIDTH+1:2]);
    err_d   = drop || (start_i && !cfg_ok) || (accept && (neg || over || inexact));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      snw_q   <= '0;
      s_q     <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q   <= accept;
      last_q <= accept && x_end && y_end;
      err_q  <= err_d;
      if (start_ok) begin
        state_q <= ST_RUN;
        x_q     <= '0;
        y_q     <= '0;
        nx_q    <= nx_i;
        ny_q    <= ny_i;
      end else if (accept) begin
        snw_q <= sn;
        s_q   <= s_clamp;
        if (x_end) begin
          x_q <= '0;
          if (y_end) begin
            y_q     <= '0;
            state_q <= ST_IDLE;
          end else begin
            y_q <= y_q + 16'd1;
          end
        end else begin
          x_q <= x_q + NX_W'(1);
        end
      end
    end
  end

  assign en_o   = en_q;
  assign s_o    = s_q;
  assign last_o = last_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_rec_s_delta.sv
// Bench for rec_s_delta: an image-level reference model predicts every output
// cycle; a single compare process checks the DUT against it on each negedge.
module tb_rec_s_delta;

  localparam int NX_W = 7;
  localparam int MAXV = 4095;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic [NX_W-1:0] nx_i = '0;
  logic [15:0]     ny_i = '0;
  logic            en_i = 1'b0;
  logic [14:0]     d_i = '0;
  logic            en_o, last_o, err_o, busy_o;
  logic [11:0]     s_o;

  rec_s_delta dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .nx_i    (nx_i),
    .ny_i    (ny_i),
    .en_i    (en_i),
    .d_i     (d_i),
    .en_o    (en_o),
    .s_o     (s_o),
    .last_o  (last_o),
    .err_o   (err_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  // Expected per-cycle word: {busy, en, last, err, s[11:0]}
  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: the reconstructed image itself.
  bit m_busy;
  int m_x, m_y, m_nx, m_ny, m_s;
  int img [4][64];
  int truth [2][4];

  function automatic int pix_m(input int y, input int x);
    if (y < 0 || x < 0 || y > 3 || x > 63) return 0;
    return img[y][x];
  endfunction

  function automatic int pix_t(input int y, input int x);
    if (y < 0 || x < 0 || y > 1 || x > 3) return 0;
    return truth[y][x];
  endfunction

  function automatic int delta_of(input int x, input int y, input int nx,
                                  input int sn, input int sne, input int snw, input int sw);
    if (x == 0 && y == 0) return 0;
    if (y == 0)           return 4 * sw;
    if (x == 0)           return 2 * sn + 2 * sne;
    if (x == nx - 1)      return 2 * snw + 2 * sn;
    return snw + 2 * sn + sne;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_x = 0; m_y = 0; m_nx = 0; m_ny = 0; m_s = 0;
  endtask

  // One clock of stimulus; lit_s / lit_err >= 0 pin the model to hand values.
  task automatic step(input bit st, input int nx, input int ny, input bit en,
                      input int d, input int lit_s, input int lit_err);
    bit e_en, e_last, e_err;
    int dl, sum, s;
    logic [15:0] e;
    e_en = 1'b0; e_last = 1'b0; e_err = 1'b0;
    start_i = st; nx_i = nx[NX_W-1:0]; ny_i = ny[15:0]; en_i = en; d_i = d[14:0];
    if (st && nx >= 2 && nx <= 64 && ny >= 1) begin
      m_busy = 1'b1; m_x = 0; m_y = 0; m_nx = nx; m_ny = ny;
      e_err = en;
    end else begin
      e_err = st;
      if (en && !m_busy) begin
        e_err = 1'b1;
      end else if (en) begin
        dl = delta_of(m_x, m_y, m_nx, pix_m(m_y-1, m_x), pix_m(m_y-1, m_x+1),
                      pix_m(m_y-1, m_x-1), pix_m(m_y, m_x-1));
        sum = dl + d;
        if (sum < 0) begin
          s = 0; e_err = 1'b1;
        end else begin
          s = sum / 4;
          if (sum % 4 != 0) e_err = 1'b1;
          if (s > MAXV) begin s = MAXV; e_err = 1'b1; end
        end
        img[m_y][m_x] = s;
        m_s = s;
        e_en = 1'b1;
        e_last = (m_x == m_nx - 1) && (m_y == m_ny - 1);
        if (m_x == m_nx - 1) begin
          m_x = 0;
          if (m_y == m_ny - 1) begin m_y = 0; m_busy = 1'b0; end
          else m_y = m_y + 1;
        end else begin
          m_x = m_x + 1;
        end
      end
    end
    if (lit_s >= 0) begin
      checks++;
      if (m_s != lit_s) begin
        failures++;
        $display("FAIL model_s got=%0d exp=%0d", m_s, lit_s);
      end
    end
    if (lit_err >= 0) begin
      checks++;
      if (int'(e_err) != lit_err) begin
        failures++;
        $display("FAIL model_err got=%0d exp=%0d", e_err, lit_err);
      end
    end
    @(posedge clk);
    #1;
    e = {m_busy, e_en, e_last, e_err, m_s[11:0]};
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, -1, -1);
  endtask

  task automatic do_reset(input bit en, input int d);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    start_i = 1'b0; en_i = en; d_i = d[14:0];
    model_reset();
    @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [15:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {busy_o, en_o, last_o, err_o, s_o};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL out_cycle t=%0t got busy=%0b en=%0b last=%0b err=%0b s=%0d exp busy=%0b en=%0b last=%0b err=%0b s=%0d",
                 $time, g[15], g[14], g[13], g[12], g[11:0], e[15], e[14], e[13], e[12], e[11:0]);
      end
    end
  end

  initial begin
    int d;
    model_reset();
    do_reset(1'b0, 0);
    idle();

    // en_i while idle, then a rejected configuration
    step(1'b0, 0, 0, 1'b1, 5, -1, 1);
    step(1'b1, 1, 2, 1'b0, 0, -1, 1);
    idle();

    // Directed 4x2 band
    step(1'b1, 4, 2, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 400, 100, 0);
    step(1'b0, 0, 0, 1'b1, 16, 104, 0);
    step(1'b0, 0, 0, 1'b1, 8, 106, 0);
    step(1'b0, 0, 0, 1'b1, 20, 111, 0);
    step(1'b0, 0, 0, 1'b1, 32, 110, 0);
    step(1'b0, 0, 0, 1'b1, 2, 104, 0);
    step(1'b0, 0, 0, 1'b1, 1, 107, 0);
    step(1'b0, 0, 0, 1'b1, 2, 109, 0);
    idle();

    // Random 4x2 band, d from an encoder over the true image, back-to-back
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        truth[y][x] = $urandom_range(0, MAXV);
    step(1'b1, 4, 2, 1'b0, 0, -1, 0);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        d = 4 * truth[y][x] - delta_of(x, y, 4, pix_t(y-1, x), pix_t(y-1, x+1),
                                       pix_t(y-1, x-1), pix_t(y, x-1));
        step(1'b0, 0, 0, 1'b1, d, truth[y][x], 0);
      end
    end
    idle();
    idle();

    // Clamping and inexact division
    step(1'b1, 4, 1, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 16383, 4095, 1);
    step(1'b0, 0, 0, 1'b1, 100, 4095, 1);
    step(1'b0, 0, 0, 1'b1, -8, 4093, 0);
    step(1'b0, 0, 0, 1'b1, -16384, 0, 1);
    step(1'b1, 2, 1, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, -8, 0, 1);
    step(1'b0, 0, 0, 1'b1, 4, 1, 0);
    step(1'b1, 2, 1, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 401, 100, 1);
    step(1'b0, 0, 0, 1'b1, 400, 200, 0);
    idle();

    // Restart while running; sample on the start cycle is dropped
    step(1'b1, 3, 2, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 400, 100, 0);
    step(1'b0, 0, 0, 1'b1, 8, 102, 0);
    step(1'b1, 3, 2, 1'b1, 12, -1, 1);
    step(1'b0, 0, 0, 1'b1, 40, 10, 0);
    step(1'b0, 0, 0, 1'b1, 0, 10, 0);

    // Reset during the third sample of a band
    step(1'b1, 4, 2, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 400, 100, 0);
    step(1'b0, 0, 0, 1'b1, 16, 104, 0);
    do_reset(1'b1, 8);
    idle();
    step(1'b1, 4, 2, 1'b0, 0, -1, 0);
    step(1'b0, 0, 0, 1'b1, 48, 12, 0);
    step(1'b0, 0, 0, 1'b1, 0, 12, 0);
    do_reset(1'b0, 0);

    // start_i and en_i together in IDLE: start wins
    step(1'b1, 2, 1, 1'b1, 400, -1, 1);
    step(1'b0, 0, 0, 1'b1, 400, 100, 0);
    step(1'b0, 0, 0, 1'b1, 4, 101, 0);
    idle();
    idle();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
